// File: rtl/div_sched_if.sv
// div_sched_if: dispatch, CDB, divider and result signals of the divide scheduler.
// master = surrounding pipeline (dispatch stage, CDB, div_unit), slave = div_sched.
interface div_sched_if;
    // Pipeline kill
    logic        flush;

    // Dispatch port
    logic        disp_valid;
    logic [2:0]  disp_funct3;
    logic [5:0]  disp_tag;
    logic [31:0] disp_op1;
    logic [31:0] disp_op2;
    logic [5:0]  disp_op1_tag;
    logic [5:0]  disp_op2_tag;
    logic        disp_op1_rdy;
    logic        disp_op2_rdy;
    logic        full;

    // Common data bus snoop
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;

    // Divider handshake
    logic        div_busy;
    logic [31:0] div_res;
    logic [5:0]  div_tag_out;
    logic        div_tag_out_valid;
    logic        div_queue_en;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [2:0]  div_funct3;
    logic [5:0]  div_tag;
    logic        div_tag_valid;

    // Result towards the CDB arbiter
    logic        res_valid;
    logic [5:0]  res_tag;
    logic [31:0] res_data;

    modport master (
        output flush,
        output disp_valid, disp_funct3, disp_tag, disp_op1, disp_op2,
        output disp_op1_tag, disp_op2_tag, disp_op1_rdy, disp_op2_rdy,
        output cdb_valid, cdb_tag, cdb_data,
        output div_busy, div_res, div_tag_out, div_tag_out_valid,
        input  full,
        input  div_queue_en, div_op1, div_op2, div_funct3, div_tag, div_tag_valid,
        input  res_valid, res_tag, res_data
    );

    modport slave (
        input  flush,
        input  disp_valid, disp_funct3, disp_tag, disp_op1, disp_op2,
        input  disp_op1_tag, disp_op2_tag, disp_op1_rdy, disp_op2_rdy,
        input  cdb_valid, cdb_tag, cdb_data,
        input  div_busy, div_res, div_tag_out, div_tag_out_valid,
        output full,
        output div_queue_en, div_op1, div_op2, div_funct3, div_tag, div_tag_valid,
        output res_valid, res_tag, res_data
    );
endinterface

// File: rtl/div_sched.sv
// div_sched: shifting-queue scheduler in front of the multi-cycle divider.
// Holds up to DEPTH pending RV32M divide/remainder ops, snoops the CDB for
// missing operands, issues the oldest ready op whenever the divider is free,
// and forwards divider results unless the op was killed by a flush.
// Optional feature: define DIV_SCHED_BYPASS_EN to let a fully-ready dispatch
// into an empty, idle scheduler issue in its own cycle.
module div_sched #(
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    div_sched_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0]  funct3;
        logic [5:0]  tag;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [5:0]  op1_tag;
        logic [5:0]  op2_tag;
        logic        op1_rdy;
        logic        op2_rdy;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_KILLED} state_t;

    entry_t        q   [DEPTH];
    entry_t        q_n [DEPTH];
    logic [CW-1:0] count;
    int            count_n;
    entry_t        d_entry;
    logic          full;
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic          can_issue;
    logic          accept;
    logic          issue_q;
    logic          bypass_issue;
    logic          issue;
    state_t        state;
    state_t        state_n;
    logic          inflight;
    logic          killed;

    assign full     = (count == CW'(DEPTH));
    assign bus.full = full;

    // Incoming op with same-cycle CDB capture so a broadcast is never missed
    always_comb begin
        d_entry         = '0;
        d_entry.funct3  = bus.disp_funct3;
        d_entry.tag     = bus.disp_tag;
        d_entry.op1_tag = bus.disp_op1_tag;
        d_entry.op2_tag = bus.disp_op2_tag;
        d_entry.op1_rdy = bus.disp_op1_rdy || (bus.cdb_valid && bus.cdb_tag == bus.disp_op1_tag);
        d_entry.op2_rdy = bus.disp_op2_rdy || (bus.cdb_valid && bus.cdb_tag == bus.disp_op2_tag);
        d_entry.op1     = bus.disp_op1_rdy ? bus.disp_op1 : bus.cdb_data;
        d_entry.op2     = bus.disp_op2_rdy ? bus.disp_op2 : bus.cdb_data;
    end

    // Pick the oldest valid entry whose operands were both captured in an earlier cycle
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it holding a value (no latch).
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && i < int'(count) && q[i].op1_rdy && q[i].op2_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    assign can_issue = !bus.flush && !inflight && !bus.div_busy;
    assign accept    = bus.disp_valid && !full && !bus.flush;
    assign issue_q   = can_issue && sel_found;

`ifdef DIV_SCHED_BYPASS_EN
    assign bypass_issue = accept && d_entry.op1_rdy && d_entry.op2_rdy && (count == '0) && can_issue;
`else
    assign bypass_issue = 1'b0;
`endif

    assign issue = issue_q || bypass_issue;

    // Next queue image: CDB wakeup, collapse over the issued slot, append the dispatch
    always_comb begin
        q_n     = q;
        count_n = int'(count);
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.cdb_valid && !q_n[i].op1_rdy && q_n[i].op1_tag == bus.cdb_tag) begin
                q_n[i].op1     = bus.cdb_data;
                q_n[i].op1_rdy = 1'b1;
            end
            if (bus.cdb_valid && !q_n[i].op2_rdy && q_n[i].op2_tag == bus.cdb_tag) begin
                q_n[i].op2     = bus.cdb_data;
                q_n[i].op2_rdy = 1'b1;
            end
        end
        if (issue_q) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (i >= int'(sel_idx)) begin
                    q_n[i] = q_n[i + 1];
                end
            end
            count_n = count_n - 1;
        end
        if (accept && !bypass_issue) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == count_n) begin
                    q_n[i] = d_entry;
                end
            end
            count_n = count_n + 1;
        end
        if (bus.flush) begin
            count_n = 0;
        end
    end

    // Queue payload storage
    // NOTE: slots are deliberately left out of reset; count alone says which slots hold live ops.
    always_ff @(posedge clk) begin
        q <= q_n;
    end

    // Occupancy counter
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            count <= '0;
        end else begin
            count <= CW'(count_n);
        end
    end

    // Divider occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Issue occupies the divider, a flush marks the in-flight op killed, its result frees the divider
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (issue) state_n = S_BUSY;
            S_BUSY: begin
                if (bus.div_tag_out_valid) begin
                    state_n = S_IDLE;
                end else if (bus.flush) begin
                    state_n = S_KILLED;
                end
            end
            S_KILLED: if (bus.div_tag_out_valid) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Issue port and result pass-through, zero when not active
    always_comb begin
        inflight          = (state != S_IDLE);
        killed            = (state == S_KILLED);
        bus.div_queue_en  = issue;
        bus.div_tag_valid = issue;
        bus.div_op1       = '0;
        bus.div_op2       = '0;
        bus.div_funct3    = '0;
        bus.div_tag       = '0;
        if (issue_q) begin
            bus.div_op1    = q[sel_idx].op1;
            bus.div_op2    = q[sel_idx].op2;
            bus.div_funct3 = q[sel_idx].funct3;
            bus.div_tag    = q[sel_idx].tag;
        end else if (bypass_issue) begin
            bus.div_op1    = d_entry.op1;
            bus.div_op2    = d_entry.op2;
            bus.div_funct3 = d_entry.funct3;
            bus.div_tag    = d_entry.tag;
        end
        bus.res_valid = bus.div_tag_out_valid && !killed;
        bus.res_tag   = bus.res_valid ? bus.div_tag_out : '0;
        bus.res_data  = bus.res_valid ? bus.div_res : '0;
    end
endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed scenarios plus randomized traffic for div_sched,
// compared every cycle against a queue-based reference model. A small
// 6-cycle divider model stands in for div_unit.
module tb_div_sched;
    localparam int DEPTH = 4;
`ifdef DIV_SCHED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int LAT = BYP ? 0 : 1;

    typedef struct packed {
        bit          rst;
        bit          flush;
        bit          dv;
        logic [2:0]  f3;
        logic [5:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  ta;
        logic [5:0]  tb;
        bit          ra;
        bit          rb;
        bit          cv;
        logic [5:0]  ctag;
        logic [31:0] cdata;
    } stim_t;

    typedef struct packed {
        logic [2:0]  f3;
        logic [5:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  ta;
        logic [5:0]  tb;
        bit          ra;
        bit          rb;
    } ment_t;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    div_sched_if bus ();

    div_sched #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    ment_t mq[$];
    exp_t  exp_q[$];
    bit    m_inflight = 0;
    bit    m_killed   = 0;

    // Last observed DUT outputs
    logic        obs_issue, obs_full, obs_res_valid, obs_busy;
    logic [5:0]  obs_dtag, obs_res_tag;
    logic [31:0] obs_op1, obs_res_data;
    int          obs_cyc;

    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd4:    ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5:    ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    ref_div = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: ref_div = (b == 0) ? a : a % b;
        endcase
    endfunction

    // Divider stand-in: accepts when idle, result valid six cycles after the issue cycle
    logic [3:0]  dv_cnt;
    logic [31:0] dv_res;
    logic [5:0]  dv_tag;
    always @(posedge clk) begin
        if (rst) begin
            dv_cnt <= 4'd0;
        end else if (dv_cnt != 4'd0) begin
            dv_cnt <= dv_cnt - 4'd1;
        end else if (bus.div_queue_en) begin
            dv_cnt <= 4'd6;
            dv_res <= ref_div(bus.div_funct3, bus.div_op1, bus.div_op2);
            dv_tag <= bus.div_tag;
        end
    end
    assign bus.div_busy          = (dv_cnt != 4'd0);
    assign bus.div_tag_out_valid = (dv_cnt == 4'd1);
    assign bus.div_res           = dv_res;
    assign bus.div_tag_out       = dv_tag;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t sd(input logic [2:0] f3, input logic [5:0] tag, input logic [31:0] a,
                                 input logic [31:0] b, input bit ra, input bit rb,
                                 input logic [5:0] ta, input logic [5:0] tb);
        stim_t s = '0;
        s.dv = 1; s.f3 = f3; s.tag = tag; s.a = a; s.b = b;
        s.ra = ra; s.rb = rb; s.ta = ta; s.tb = tb;
        return s;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3, 4:    return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = '0;
        s.dv    = ($urandom_range(0, 99) < 45);
        s.f3    = 3'($urandom_range(4, 7));
        s.tag   = 6'($urandom);
        s.a     = rand_op();
        s.b     = rand_op();
        s.ra    = 1'($urandom_range(0, 1));
        s.rb    = 1'($urandom_range(0, 1));
        s.ta    = 6'($urandom_range(0, 7));
        s.tb    = 6'($urandom_range(0, 7));
        s.cv    = ($urandom_range(0, 99) < 35);
        s.ctag  = 6'($urandom_range(0, 7));
        s.cdata = rand_op();
        s.flush = ($urandom_range(0, 99) < 3);
        return s;
    endfunction

    // One clock cycle: drive, compare against the model at the falling edge, advance the model
    task automatic step(input stim_t s);
        int    idx;
        bit    can, acc, byp, iss, ev, tov;
        ment_t d, ie;
        exp_t  e;
        logic [5:0]  et;
        logic [31:0] ed;

        rst              = s.rst;
        bus.flush        = s.flush;
        bus.disp_valid   = s.dv;
        bus.disp_funct3  = s.f3;
        bus.disp_tag     = s.tag;
        bus.disp_op1     = s.a;
        bus.disp_op2     = s.b;
        bus.disp_op1_tag = s.ta;
        bus.disp_op2_tag = s.tb;
        bus.disp_op1_rdy = s.ra;
        bus.disp_op2_rdy = s.rb;
        bus.cdb_valid    = s.cv;
        bus.cdb_tag      = s.ctag;
        bus.cdb_data     = s.cdata;

        @(negedge clk);

        can = !s.flush && !m_inflight && !bus.div_busy;
        idx = -1;
        if (can) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (idx < 0 && mq[i].ra && mq[i].rb) idx = i;
            end
        end
        d     = '0;
        d.f3  = s.f3;
        d.tag = s.tag;
        d.ta  = s.ta;
        d.tb  = s.tb;
        d.ra  = s.ra || (s.cv && s.ctag == s.ta);
        d.rb  = s.rb || (s.cv && s.ctag == s.tb);
        d.a   = s.ra ? s.a : s.cdata;
        d.b   = s.rb ? s.b : s.cdata;
        acc   = s.dv && (mq.size() < DEPTH) && !s.flush;
        byp   = BYP && acc && d.ra && d.rb && (mq.size() == 0) && can;
        iss   = (idx >= 0) || byp;
        ie    = '0;
        if (idx >= 0) ie = mq[idx];
        else if (byp) ie = d;

        tov = bus.div_tag_out_valid;
        ev  = tov && !m_killed;
        et  = 6'd0;
        ed  = 32'd0;
        if (ev && exp_q.size() > 0) begin
            et = exp_q[0].tag;
            ed = exp_q[0].data;
        end

        check("full",       32'(bus.full),          32'(mq.size() == DEPTH));
        check("issue_en",   32'(bus.div_queue_en),  32'(iss));
        check("tag_valid",  32'(bus.div_tag_valid), 32'(iss));
        check("div_op1",    bus.div_op1,            ie.a);
        check("div_op2",    bus.div_op2,            ie.b);
        check("div_funct3", 32'(bus.div_funct3),    32'(ie.f3));
        check("div_tag",    32'(bus.div_tag),       32'(ie.tag));
        check("res_valid",  32'(bus.res_valid),     32'(ev));
        check("res_tag",    32'(bus.res_tag),       32'(et));
        check("res_data",   bus.res_data,           ed);

        obs_issue     = bus.div_queue_en;
        obs_full      = bus.full;
        obs_busy      = bus.div_busy;
        obs_dtag      = bus.div_tag;
        obs_op1       = bus.div_op1;
        obs_res_valid = bus.res_valid;
        obs_res_tag   = bus.res_tag;
        obs_res_data  = bus.res_data;
        obs_cyc       = cyc;

        if (s.rst) begin
            mq.delete();
            exp_q.delete();
            m_inflight = 0;
            m_killed   = 0;
        end else begin
            if (tov && exp_q.size() > 0) void'(exp_q.pop_front());
            m_killed = m_inflight && !tov && (m_killed || s.flush);
            if (tov) m_inflight = 0;
            if (iss) begin
                m_inflight = 1;
                e.tag  = ie.tag;
                e.data = ref_div(ie.f3, ie.a, ie.b);
                exp_q.push_back(e);
            end
            if (s.flush) begin
                mq.delete();
            end else begin
                if (s.cv) begin
                    foreach (mq[i]) begin
                        if (!mq[i].ra && mq[i].ta == s.ctag) begin mq[i].a = s.cdata; mq[i].ra = 1; end
                        if (!mq[i].rb && mq[i].tb == s.ctag) begin mq[i].b = s.cdata; mq[i].rb = 1; end
                    end
                end
                if (idx >= 0) mq.delete(idx);
                if (acc && !byp) mq.push_back(d);
            end
        end

        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Step idle cycles until a result appears (bounded), then check it
    task automatic wait_res(input string name, input logic [5:0] tag, input logic [31:0] data);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(idle());
            if (obs_res_valid) got = 1;
        end
        check({name, "_seen"}, 32'(got), 32'd1);
        check({name, "_tag"},  32'(obs_res_tag), 32'(tag));
        check({name, "_data"}, obs_res_data, data);
    endtask

    initial begin
        stim_t s;
        int    prev, n;

        s = idle();
        s.rst = 1;
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.disp_valid = 1'b0;
        bus.cdb_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        step(s);
        check("rst_full",  32'(obs_full),      32'd0);
        check("rst_issue", 32'(obs_issue),     32'd0);
        check("rst_res",   32'(obs_res_valid), 32'd0);
        step(idle());

        // DIVU 100/7, both ready: issue after LAT cycles, result 14 six cycles later
        step(sd(3'd5, 6'd5, 32'd100, 32'd7, 1, 1, 6'd0, 6'd0));
        check("s1_issue_n", 32'(obs_issue), 32'(BYP));
        repeat (LAT) step(idle());
        check("s1_issue", 32'(obs_issue), 32'd1);
        check("s1_op1",   obs_op1,        32'd100);
        repeat (5) begin
            step(idle());
            check("s1_res_early", 32'(obs_res_valid), 32'd0);
        end
        step(idle());
        check("s1_res_valid", 32'(obs_res_valid), 32'd1);
        check("s1_res_tag",   32'(obs_res_tag),   32'd5);
        check("s1_res_data",  obs_res_data,       32'd14);
        step(idle());

        // Younger ready op overtakes an older waiting one
        step(sd(3'd7, 6'd3, 32'd23, 32'd0, 1, 0, 6'd0, 6'd9));
        step(sd(3'd7, 6'd4, 32'd17, 32'd5, 1, 1, 6'd0, 6'd0));
        step(idle());
        check("s2_first_tag", 32'(obs_dtag), 32'd4);
        s = idle(); s.cv = 1; s.ctag = 6'd9; s.cdata = 32'd5;
        step(s);
        wait_res("s2_tag4", 6'd4, 32'd2);
        wait_res("s2_tag3", 6'd3, 32'd3);
        repeat (3) step(idle());

        // Fill the queue, refuse a fifth op, free a slot on the first issue
        for (int i = 0; i < 4; i++) step(sd(3'd5, 6'(40 + i), 32'(30 + i), 32'd0, 1, 0, 6'd0, 6'd20));
        step(sd(3'd5, 6'd63, 32'd9, 32'd3, 1, 1, 6'd0, 6'd0));
        check("s3_full", 32'(obs_full), 32'd1);
        s = idle(); s.cv = 1; s.ctag = 6'd20; s.cdata = 32'd3;
        step(s);
        step(idle());
        check("s3_issue",      32'(obs_issue), 32'd1);
        check("s3_full_issue", 32'(obs_full),  32'd1);
        step(idle());
        check("s3_full_after", 32'(obs_full),  32'd0);
        repeat (40) step(idle());

        // Operand captured from a same-cycle CDB broadcast at dispatch
        s = sd(3'd5, 6'd11, 32'd0, 32'd8, 0, 1, 6'd12, 6'd0);
        s.cv = 1; s.ctag = 6'd12; s.cdata = 32'd40;
        step(s);
        repeat (LAT) step(idle());
        check("s4_issue", 32'(obs_issue), 32'd1);
        check("s4_op1",   obs_op1,        32'd40);
        wait_res("s4", 6'd11, 32'd5);
        step(idle());

        // Flush kills the in-flight result; the next op waits for the divider
        step(sd(3'd5, 6'd7, 32'd50, 32'd5, 1, 1, 6'd0, 6'd0));
        repeat (LAT) step(idle());
        check("s5_issue", 32'(obs_issue), 32'd1);
        step(idle());
        s = idle(); s.flush = 1;
        step(s);
        step(sd(3'd5, 6'd8, 32'd60, 32'd6, 1, 1, 6'd0, 6'd0));
        check("s5_no_issue", 32'(obs_issue), 32'd0);
        repeat (3) begin
            step(idle());
            check("s5_killed", 32'(obs_res_valid), 32'd0);
            check("s5_wait",   32'(obs_issue),     32'd0);
        end
        step(idle());
        check("s5_next_issue", 32'(obs_issue), 32'd1);
        check("s5_next_tag",   32'(obs_dtag),  32'd8);
        repeat (10) step(idle());

        // Back-to-back ready ops: issues exactly seven cycles apart, never while busy
        prev = -1;
        n = 0;
        for (int i = 0; i < 35; i++) begin
            s = (i < 3) ? sd(3'd4, 6'(50 + i), 32'(-100 + i), 32'd7, 1, 1, 6'd0, 6'd0) : idle();
            step(s);
            check("b2b_busy", 32'(obs_issue && obs_busy), 32'd0);
            if (obs_issue) begin
                if (prev >= 0) check("b2b_gap", 32'(obs_cyc - prev), 32'd7);
                prev = obs_cyc;
                n++;
            end
        end
        check("b2b_count", 32'(n), 32'd3);

        // Random traffic with one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            s = rand_stim();
            if (i == 1500) s.rst = 1;
            step(s);
        end
        repeat (40) step(idle());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1);
    end
endmodule
